// File: rtl/oven_led_sequencer.sv
// oven_led_sequencer -- arbitrates oven requesters onto one LED and plays its blink pattern.
// Optional power-on lamp test under `LED_SELFTEST_EN. Rev 1.0
`default_nettype none

module oven_led_sequencer #(
   parameter int unsigned SLOW_HALF       = 8,
   parameter int unsigned FAST_HALF       = 2,
   parameter int unsigned DONE_BLINKS     = 3,
   parameter int unsigned SELFTEST_CYCLES = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       err_req,
   input  logic       done_pulse,
   input  logic       preheat_req,
   input  logic       heat_req,
   output logic       done_busy,
   output logic [2:0] mode,
   output logic       led
);

   localparam int unsigned C_MAX_AB = (SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF;
   localparam int unsigned C_MAX    = (C_MAX_AB > SELFTEST_CYCLES) ? C_MAX_AB : SELFTEST_CYCLES;
   localparam int unsigned C_CW     = $clog2(C_MAX + 1);
   localparam int unsigned C_BW     = $clog2(DONE_BLINKS + 1);

   localparam logic [C_CW-1:0] C_SLOW_LAST = C_CW'(SLOW_HALF - 1);
   localparam logic [C_CW-1:0] C_FAST_LAST = C_CW'(FAST_HALF - 1);
   localparam logic [C_CW-1:0] C_CNT_ONE   = C_CW'(1);
   localparam logic [C_BW-1:0] C_BLK_LAST  = C_BW'(DONE_BLINKS - 1);
   localparam logic [C_BW-1:0] C_BLK_ONE   = C_BW'(1);

   typedef enum logic [2:0] {
      MODE_OFF      = 3'd0,
      MODE_ON       = 3'd1,
      MODE_SLOW     = 3'd2,
      MODE_FAST_ERR = 3'd3,
      MODE_DONE     = 3'd4,
      MODE_SELFTEST = 3'd5
   } mode_t;

   mode_t           r_mode, w_mode_nx;
   logic [C_CW-1:0] r_cnt, w_cnt_nx;
   logic            r_phase, w_phase_nx;
   logic [C_BW-1:0] r_blink, w_blink_nx;
   logic            r_done_busy, w_done_nx;
   logic [C_CW-1:0] w_last;
   logic            w_half_end;
   logic            w_done_end;
   logic            w_blinking;
   logic            w_st_hold;

`ifdef LED_SELFTEST_EN
   localparam logic [C_CW-1:0] C_ST_LAST = C_CW'(SELFTEST_CYCLES - 1);
   localparam mode_t           C_RST_MODE = MODE_SELFTEST;
   assign w_st_hold = (r_mode == MODE_SELFTEST) && (r_cnt != C_ST_LAST);
`else
   localparam mode_t           C_RST_MODE = MODE_OFF;
   assign w_st_hold = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mode      <= C_RST_MODE;
         r_cnt       <= '0;
         r_phase     <= 1'b0;
         r_blink     <= '0;
         r_done_busy <= 1'b0;
      end else begin
         r_mode      <= w_mode_nx;
         r_cnt       <= w_cnt_nx;
         r_phase     <= w_phase_nx;
         r_blink     <= w_blink_nx;
         r_done_busy <= w_done_nx;
      end
   end

   always_comb begin
      w_last     = (r_mode == MODE_SLOW) ? C_SLOW_LAST : C_FAST_LAST;
      w_half_end = (r_cnt == w_last);
      w_blinking = (r_mode == MODE_SLOW) || (r_mode == MODE_FAST_ERR) || (r_mode == MODE_DONE);
      // The last off half of the final done blink ends the sequence.
      w_done_end = (r_mode == MODE_DONE) && w_half_end && !r_phase && (r_blink == C_BLK_LAST);
   end

   always_comb begin
      w_mode_nx  = r_mode;
      w_cnt_nx   = r_cnt;
      w_phase_nx = r_phase;
      w_blink_nx = r_blink;
      w_done_nx  = 1'b0;

      if (w_st_hold) begin
         w_cnt_nx = r_cnt + C_CNT_ONE;
      end else begin
         if (err_req)
            w_done_nx = 1'b0;
         else if (r_done_busy)
            w_done_nx = !w_done_end;
         else
            w_done_nx = done_pulse;

         if (err_req)
            w_mode_nx = MODE_FAST_ERR;
         else if (w_done_nx)
            w_mode_nx = MODE_DONE;
         else if (preheat_req)
            w_mode_nx = MODE_SLOW;
         else if (heat_req)
            w_mode_nx = MODE_ON;
         else
            w_mode_nx = MODE_OFF;

         if (w_mode_nx != r_mode) begin
            w_cnt_nx   = '0;
            w_phase_nx = 1'b1;
            w_blink_nx = '0;
         end else if (w_blinking) begin
            if (w_half_end) begin
               w_cnt_nx   = '0;
               w_phase_nx = !r_phase;
               if ((r_mode == MODE_DONE) && !r_phase)
                  w_blink_nx = r_blink + C_BLK_ONE;
            end else begin
               w_cnt_nx = r_cnt + C_CNT_ONE;
            end
         end
      end
   end

   always_comb begin
      case (r_mode)
         MODE_ON, MODE_SELFTEST:              led = 1'b1;
         MODE_SLOW, MODE_FAST_ERR, MODE_DONE: led = r_phase;
         default:                             led = 1'b0;
      endcase
   end

   assign mode      = r_mode;
   assign done_busy = r_done_busy;

endmodule

`default_nettype wire
